// File: rtl/mem_pkg.sv
// Shared types for the RV32 data memory: funct3 codes, controller states, data width.
package mem_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response channel between the mem stage (master) and the data memory (slave).
interface data_mem_ctrl_if;
  import mem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_align.sv
// Combinational lane logic: store byte-enables and replication, access legality,
// load lane extraction with sign/zero extension.
module data_mem_align
  import mem_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  output logic            err,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);
  logic [XLEN-1:0] sh;

  // Legality check and store lane steering; errored or load accesses never enable a byte.
  always_comb begin
    err       = 1'b0;
    be        = 4'b0000;
    wdata_rep = {4{wdata[7:0]}};
    case (funct3_e'(funct3))
      F3_B:  be = 4'b0001 << off;
      F3_H:  begin
        err       = off[0];
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_W:  begin
        err       = (off != 2'b00);
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      F3_BU: err = we;
      F3_HU: err = we | off[0];
      default: err = 1'b1;
    endcase
    if (err || !we) be = 4'b0000;
  end

  // Shift the addressed lane down to bit 0, then extend per load type.
  always_comb begin
    sh = ld_word >> {ld_off, 3'b000};
    case (funct3_e'(ld_funct3))
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_W:    ld_data = sh;
      F3_BU:   ld_data = {24'b0, sh[7:0]};
      F3_HU:   ld_data = {16'b0, sh[15:0]};
      default: ld_data = '0;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 data memory: hardware clear after reset, byte-lane stores, registered
// 1-cycle load response, read-first debug port.
module data_mem_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_ctrl_if.slave    bus,
  output logic              busy,
  input  logic [ADDR_W-1:0] ext_addr,
  output logic [XLEN-1:0]   ext_data
);
  import mem_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              acc;
  logic [ADDR_W-1:0] idx;
  logic              err;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata_rep;
  logic              ld_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   rword_q;
  logic [XLEN-1:0]   ld_data;
  logic              unused_addr_hi;

  // Upper address bits alias onto the array.
  assign idx            = bus.req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:ADDR_W+2];
  assign acc            = bus.req_valid & bus.req_ready;

  data_mem_align u_align (
    .we        (bus.req_we),
    .funct3    (bus.req_funct3),
    .off       (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .err       (err),
    .be        (be),
    .wdata_rep (wdata_rep),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (rword_q),
    .ld_data   (ld_data)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs: traffic only once the array is cleared.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN:     bus.req_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  // Clear index walks every word once, restarting from 0 on any reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // Array port: clear writes, byte-enabled stores, read-first load capture.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (acc) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
    if (acc) rword_q <= mem[idx];
  end

  // Response pipe and debug read register; reset drops any response in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      ld_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      ext_data      <= '0;
    end else begin
      bus.rsp_valid <= acc;
      bus.rsp_err   <= acc & err;
      ld_q          <= acc & ~bus.req_we & ~err;
      f3_q          <= bus.req_funct3;
      off_q         <= bus.req_addr[1:0];
      ext_data      <= mem[ext_addr];
    end
  end

  assign bus.rsp_rdata = ld_q ? ld_data : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus randomized traffic against a
// word-array reference model.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [7:0]  ext_addr;
  logic [31:0] ext_data;

  always #5 clk = ~clk;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.XLEN(32), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ext_addr (ext_addr),
    .ext_data (ext_data)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] model [256];

  function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (f3 == 3'd3 || f3 > 3'd5) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    int unsigned b, h;
    s = w >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'hFFFF_FF00 + b : b;
      3'd1:    return (h >= 32768) ? 32'hFFFF_0000 + h : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] a);
    return (a / 4) % 256;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  // One request, accepted at the next edge; response checked one cycle later.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string nm, output logic [31:0] got);
    logic [31:0] exp_d, w;
    logic        exp_e;
    int          wi, n, pos;
    wi    = widx(a);
    exp_e = is_err(we, f3, a);
    exp_d = (!we && !exp_e) ? load_val(model[wi], f3, a[1:0]) : 32'h0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== exp_e || bus.rsp_rdata !== exp_d) begin
      fails++;
      $display("FAIL %s: got valid=%b err=%b rdata=%h, expected valid=1 err=%b rdata=%h",
               nm, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, exp_e, exp_d);
    end
    if (we && !exp_e) begin
      w = model[wi];
      n = 1 << f3;
      for (int k = 0; k < n; k++) begin
        pos = a[1:0] + k;
        w[8*pos +: 8] = wd[8*k +: 8];
      end
      model[wi] = w;
    end
    got = bus.rsp_rdata;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    int n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; ext_addr = 8'h0;
    rst = 1'b1;
    #12;
    tests++;
    if (busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 || ext_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b ready=%b rsp_valid=%b err=%b rdata=%h ext=%h, expected 1 0 0 0 0 0",
               busy, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, ext_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear(n);
    check_val("clear_cycles", n, 256);
    check_val("ready_after_clear", {31'b0, bus.req_ready}, 32'h1);
    model_clear();
    for (int i = 0; i < 6; i++) begin
      ext_addr = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check_val("ext_zero_after_clear", ext_data, 32'h0);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] g;
    do_op(1, 3'd2, 32'h10, 32'h8000_00F1, "sw_10", g);
    do_op(0, 3'd0, 32'h10, 32'h0, "lb_10", g);  check_val("lb_10_lit", g, 32'hFFFF_FFF1);
    do_op(0, 3'd4, 32'h13, 32'h0, "lbu_13", g); check_val("lbu_13_lit", g, 32'h0000_0080);
    do_op(0, 3'd1, 32'h12, 32'h0, "lh_12", g);  check_val("lh_12_lit", g, 32'hFFFF_8000);
    do_op(0, 3'd5, 32'h10, 32'h0, "lhu_10", g); check_val("lhu_10_lit", g, 32'h0000_00F1);
  endtask

  task automatic test_byte_lane();
    logic [31:0] g;
    do_op(1, 3'd2, 32'h20, 32'h1122_3344, "sw_20", g);
    do_op(1, 3'd0, 32'h21, 32'h0000_00AB, "sb_21", g);
    do_op(0, 3'd2, 32'h20, 32'h0, "lw_20_a", g); check_val("sb_lane_lit", g, 32'h1122_AB44);
    do_op(1, 3'd1, 32'h22, 32'h0000_BEEF, "sh_22", g);
    do_op(0, 3'd2, 32'h20, 32'h0, "lw_20_b", g); check_val("sh_lane_lit", g, 32'hBEEF_AB44);
  endtask

  task automatic test_errors();
    logic [31:0] g;
    do_op(1, 3'd2, 32'h04, 32'h5555_AAAA, "sw_04", g);
    do_op(1, 3'd2, 32'h06, 32'h1234_5678, "sw_misaligned", g);
    do_op(0, 3'd1, 32'h0B, 32'h0, "lh_misaligned", g);
    do_op(0, 3'd3, 32'h04, 32'h0, "ld_funct3_3", g);
    do_op(1, 3'd4, 32'h04, 32'hFFFF_FFFF, "st_funct3_4", g);
    do_op(0, 3'd2, 32'h04, 32'h0, "lw_04", g); check_val("word04_unchanged", g, 32'h5555_AAAA);
  endtask

  task automatic test_back_to_back();
    logic [31:0] g, old;
    ext_addr = 8'h10;
    old = model[16];
    do_op(1, 3'd2, 32'h40, 32'hDEAD_BEEF, "b2b_sw", g);
    check_val("ext_read_first", ext_data, old);
    do_op(0, 3'd2, 32'h40, 32'h0, "b2b_lw", g);
    check_val("b2b_lw_lit", g, 32'hDEAD_BEEF);
    check_val("ext_new_value", ext_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check_val("rsp_valid_idle", {31'b0, bus.rsp_valid}, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] g, a, exp_ext;
    logic        we;
    logic [2:0]  f3;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      ext_addr = 8'($urandom_range(0, 15));
      exp_ext  = model[ext_addr];
      do_op(we, f3, a, $urandom, "rand_op", g);
      check_val("rand_ext", ext_data, exp_ext);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check_val("rand_idle_valid", {31'b0, bus.rsp_valid}, 32'h0);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] g;
    int n;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_clear_busy", {30'b0, busy, bus.req_ready}, 32'h2);
    rst = 1'b0;
    wait_clear(n);
    check_val("abort_clear_cycles", n, 256);
    model_clear();
    do_op(1, 3'd2, 32'h80, 32'hCAFE_F00D, "run_sw", g);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h80;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_val("inflight_valid", {31'b0, bus.rsp_valid}, 32'h1);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_inflight: rsp_valid=%b rdata=%h busy=%b, expected 0 0 1",
               bus.rsp_valid, bus.rsp_rdata, busy);
    end
    rst = 1'b0;
    wait_clear(n);
    check_val("abort_run_cycles", n, 256);
    model_clear();
    do_op(0, 3'd2, 32'h80, 32'h0, "lw_80_cleared", g);
    do_op(0, 3'd2, 32'h40, 32'h0, "lw_40_cleared", g);
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_byte_lane();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
